// File: rtl/bf_out_uart.sv
// bf_out_uart: byte FIFO plus UART transmitter for the Brainfuck core's output stream.
// Define BF_OUT_PARITY_EN for 8E1 frames (even parity bit); the default build sends 8N1.
module bf_out_uart #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       out_valid,
    input  logic [7:0] out_data,
    output logic       stall,
    output logic       txd,
    output logic       busy,
    output logic       overflow
);
    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned BW  = $clog2(DIV);

    localparam logic [AW:0]   FULL_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   HIGH_C  = (AW+1)'(FIFO_DEPTH - 1);
    localparam logic [BW-1:0] BAUD_MAX = BW'(DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef BF_OUT_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    state_e        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
`ifdef BF_OUT_PARITY_EN
    logic          parity_q;
`endif

    logic wr_en, pop, bit_end;

    // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot for the write.
    assign wr_en   = out_valid && (count_q < FULL_C);
    assign pop     = (state_q == StIdle) && (count_q != '0);
    assign bit_end = (baud_q == BAUD_MAX);
    assign stall   = (count_q >= HIGH_C);
    assign busy    = (state_q != StIdle) || (count_q != '0);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= out_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (out_valid && !wr_en) begin
                overflow <= 1'b1;
            end
            unique case ({wr_en, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // txd is driven from the current state, so the line lags the FSM by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd      <= 1'b1;
`ifdef BF_OUT_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            baud_q <= ((state_q == StIdle) || bit_end) ? '0 : baud_q + BW'(1);
            unique case (state_q)
                StIdle: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shift_q  <= mem_q[rd_ptr_q];
`ifdef BF_OUT_PARITY_EN
                        parity_q <= ^mem_q[rd_ptr_q];
`endif
                        state_q  <= StStart;
                    end
                end
                StStart: begin
                    txd <= 1'b0;
                    if (bit_end) begin
                        bit_q   <= '0;
                        state_q <= StData;
                    end
                end
                StData: begin
                    txd <= shift_q[0];
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef BF_OUT_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end
                    end
                end
`ifdef BF_OUT_PARITY_EN
                StParity: begin
                    txd <= parity_q;
                    if (bit_end) begin
                        state_q <= StStop;
                    end
                end
`endif
                StStop: begin
                    txd <= 1'b1;
                    if (bit_end) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
